// File: rtl/fifo_wr_packer_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_packer_if
// Bundles the narrow ingress beat stream and the wide FIFO write port that
// fifo_wr_packer sits between.
//   s_valid/s_ready/s_data/s_last : ingress beat stream (valid/ready)
//   o_wren/o_wrdata               : FIFO write port, one word per o_wren cycle
//   i_full/i_alm_full             : FIFO status flags
// Modports:
//   slave  - the packer's view (consumes beats, drives the FIFO write port)
//   master - the environment's view (beat source plus FIFO)
// ----------------------------------------------------------------------------
interface fifo_wr_packer_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 128
);
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic             s_last;
    logic             o_wren;
    logic [OUT_W-1:0] o_wrdata;
    logic             i_full;
    logic             i_alm_full;

    modport slave (
        input  s_valid, s_data, s_last, i_full, i_alm_full,
        output s_ready, o_wren, o_wrdata
    );

    modport master (
        output s_valid, s_data, s_last, i_full, i_alm_full,
        input  s_ready, o_wren, o_wrdata
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// ----------------------------------------------------------------------------
// fifo_wr_packer
// Packs RATIO = OUT_W/IN_W narrow beats into one FIFO word, lane 0 in the
// LSBs. A packet ending before the word fills is zero-padded and flushed so
// every packet starts on a fresh FIFO word. A single hold register sits in
// front of the FIFO and is refilled in the same cycle it drains, giving one
// beat per cycle of sustained throughput.
// Ports:
//   clk        : clock, all logic on posedge
//   reset      : synchronous, active-high; discards any partial or held word
//   bus        : fifo_wr_packer_if.slave (beat stream + FIFO write port)
//   o_throttle : i_alm_full delayed one cycle, for the upstream source
//   o_busy     : partial word in the accumulator or a word waiting to write
//   o_word_cnt : FIFO words written since reset (wraps)
//   o_pkt_cnt  : packets (s_last beats) accepted since reset (wraps)
// ----------------------------------------------------------------------------
module fifo_wr_packer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 128,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    fifo_wr_packer_if.slave     bus,
    output logic                o_throttle,
    output logic                o_busy,
    output logic [CNT_W-1:0]    o_word_cnt,
    output logic [CNT_W-1:0]    o_pkt_cnt
);
    localparam int RATIO  = OUT_W / IN_W;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    if ((OUT_W % IN_W) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("fifo_wr_packer: OUT_W must be a multiple of IN_W with OUT_W/IN_W >= 2");
    end

    logic [OUT_W-1:0]  acc;
    logic [LANE_W-1:0] lane;
    logic [OUT_W-1:0]  hold_data;
    logic              hold_valid;

    logic              acc_fire;
    logic              wr_fire;
    logic              word_done;
    logic [OUT_W-1:0]  word_next;

    // The FIFO's full flag is registered, so gating ready/wren on it
    // combinationally does not close a loop.
    assign wr_fire     = hold_valid && !bus.i_full && !reset;
    assign bus.s_ready = !reset && (!hold_valid || wr_fire);
    assign bus.o_wren  = wr_fire;
    assign bus.o_wrdata = hold_data;

    assign acc_fire  = bus.s_valid && bus.s_ready;
    assign word_done = (lane == LAST_LANE) || bus.s_last;
    assign o_busy    = (lane != '0) || hold_valid;

    // Current beat merged into the accumulator. Lanes above the current one
    // are still zero because acc is cleared whenever a word is handed off.
    always_comb begin
        // NOTE: the full default first keeps every bit assigned on every
        // path, so no latch is inferred for the partially written vector.
        word_next = acc;
        word_next[lane*IN_W +: IN_W] = bus.s_data;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register here sample the
        // pre-edge values, so the order of the statements does not matter.
        if (reset) begin
            acc        <= '0;
            lane       <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            o_throttle <= 1'b0;
            o_word_cnt <= '0;
            o_pkt_cnt  <= '0;
        end else begin
            o_throttle <= bus.i_alm_full;

            if (acc_fire && word_done) begin
                // Load wins over drain: a simultaneous write leaves the
                // hold register full with the new word.
                hold_data  <= word_next;
                hold_valid <= 1'b1;
                acc        <= '0;
                lane       <= '0;
            end else begin
                if (wr_fire) begin
                    hold_valid <= 1'b0;
                end
                if (acc_fire) begin
                    acc  <= word_next;
                    lane <= lane + 1'b1;
                end
            end

            if (wr_fire) begin
                o_word_cnt <= o_word_cnt + CNT_W'(1);
            end
            if (acc_fire && bus.s_last) begin
                o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_packer.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_packer
// Directed bench for fifo_wr_packer (IN_W=32, OUT_W=128, RATIO=4). Inputs
// change 1 time unit after the falling edge; combinational outputs are
// checked shortly after that, registered outputs after the rising edge.
// A monitor logs every written FIFO word on the falling edge.
// ----------------------------------------------------------------------------
module tb_fifo_wr_packer;
    localparam int IN_W  = 32;
    localparam int OUT_W = 128;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             o_throttle;
    logic             o_busy;
    logic [CNT_W-1:0] o_word_cnt;
    logic [CNT_W-1:0] o_pkt_cnt;

    int tests = 0;
    int fails = 0;

    logic [OUT_W-1:0] wr_q[$];
    logic [OUT_W-1:0] exp_q[$];

    fifo_wr_packer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    fifo_wr_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_throttle (o_throttle),
        .o_busy     (o_busy),
        .o_word_cnt (o_word_cnt),
        .o_pkt_cnt  (o_pkt_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_wren === 1'b1) wr_q.push_back(bus.o_wrdata);
    end

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic last);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        next_cycle();
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
    endtask

    initial begin : stim
        logic       ready_ok;
        logic       stall_ok;
        logic [8:0] wren_pat;
        logic [4:0] thr_pat;
        int         n_before;

        reset = 1'b1;
        bus.i_full = 1'b0;
        bus.i_alm_full = 1'b0;
        idle();

        // ---- reset state
        next_cycle();
        next_cycle();
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_o_wren", bus.o_wren, 0);
        reset = 1'b0;
        #1;
        check("rst_s_ready_after", bus.s_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_wrdata", bus.o_wrdata, 0);
        check("rst_throttle", o_throttle, 0);
        check("rst_word_cnt", o_word_cnt, 0);
        check("rst_pkt_cnt", o_pkt_cnt, 0);

        // ---- full word
        send(32'h11111111, 1'b0);
        check("full_busy_mid", o_busy, 1);
        send(32'h22222222, 1'b0);
        send(32'h33333333, 1'b0);
        send(32'h44444444, 1'b1);
        idle();
        #1;
        check("full_wren", bus.o_wren, 1);
        check("full_wrdata", bus.o_wrdata, 128'h44444444_33333333_22222222_11111111);
        next_cycle();
        check("full_wren_off", bus.o_wren, 0);
        check("full_word_cnt", o_word_cnt, 1);
        check("full_pkt_cnt", o_pkt_cnt, 1);
        check("full_busy_done", o_busy, 0);

        // ---- short packet, zero-padded
        send(32'hAAAAAAAA, 1'b0);
        send(32'hBBBBBBBB, 1'b1);
        idle();
        #1;
        check("short_wren", bus.o_wren, 1);
        check("short_wrdata", bus.o_wrdata, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
        next_cycle();
        check("short_busy", o_busy, 0);
        check("short_word_cnt", o_word_cnt, 2);
        check("short_pkt_cnt", o_pkt_cnt, 2);

        // ---- throughput: 8 back-to-back beats
        wr_q.delete();
        ready_ok = 1'b1;
        wren_pat = '0;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'hC0DE0000 | i;
            bus.s_last  = 1'b0;
            #1;
            ready_ok    = ready_ok & bus.s_ready;
            wren_pat[i] = bus.o_wren;
            next_cycle();
        end
        idle();
        #1;
        wren_pat[8] = bus.o_wren;
        next_cycle();
        check("tput_ready_const", ready_ok, 1);
        check("tput_wren_pattern", wren_pat, 9'b1_0001_0000);
        check("tput_word_cnt", o_word_cnt, 4);
        check("tput_n_words", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("tput_word0", wr_q[0], 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);
            check("tput_word1", wr_q[1], 128'hC0DE0007_C0DE0006_C0DE0005_C0DE0004);
        end
        check("tput_busy", o_busy, 0);

        // ---- backpressure with scoreboard
        wr_q.delete();
        exp_q.delete();
        send(32'hD0000000, 1'b0);
        send(32'hD0000001, 1'b0);
        send(32'hD0000002, 1'b0);
        send(32'hD0000003, 1'b0);
        exp_q.push_back(128'hD0000003_D0000002_D0000001_D0000000);
        bus.i_full  = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hD0000004;
        bus.s_last  = 1'b0;
        stall_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            stall_ok = stall_ok & (bus.o_wren === 1'b0) & (bus.s_ready === 1'b0) & (o_busy === 1'b1)
                     & (bus.o_wrdata === 128'hD0000003_D0000002_D0000001_D0000000);
            next_cycle();
        end
        check("bp_stall_hold", stall_ok, 1);
        bus.i_full = 1'b0;
        #1;
        check("bp_release_ready", bus.s_ready, 1);
        check("bp_release_wren", bus.o_wren, 1);
        next_cycle();
        send(32'hD0000005, 1'b0);
        send(32'hD0000006, 1'b0);
        send(32'hD0000007, 1'b1);
        exp_q.push_back(128'hD0000007_D0000006_D0000005_D0000004);
        idle();
        next_cycle();
        check("bp_n_words", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check($sformatf("bp_word%0d", i), wr_q[i], exp_q[i]);
        end
        check("bp_word_cnt", o_word_cnt, 6);
        check("bp_pkt_cnt", o_pkt_cnt, 3);

        // ---- reset mid-word
        send(32'hE0000000, 1'b0);
        send(32'hE0000001, 1'b0);
        idle();
        reset = 1'b1;
        #1;
        check("rmid_ready_in_reset", bus.s_ready, 0);
        next_cycle();
        reset = 1'b0;
        #1;
        check("rmid_busy", o_busy, 0);
        check("rmid_word_cnt", o_word_cnt, 0);
        check("rmid_pkt_cnt", o_pkt_cnt, 0);
        send(32'hF0000000, 1'b0);
        send(32'hF0000001, 1'b0);
        send(32'hF0000002, 1'b0);
        send(32'hF0000003, 1'b1);
        idle();
        #1;
        check("rmid_clean_wren", bus.o_wren, 1);
        check("rmid_clean_word", bus.o_wrdata, 128'hF0000003_F0000002_F0000001_F0000000);
        next_cycle();
        check("rmid_word_cnt_after", o_word_cnt, 1);

        // ---- reset while a word is held and the FIFO has room
        send(32'h90000000, 1'b0);
        send(32'h90000001, 1'b0);
        send(32'h90000002, 1'b0);
        send(32'h90000003, 1'b0);
        idle();
        reset = 1'b1;
        n_before = wr_q.size();
        #1;
        check("rhold_wren_in_reset", bus.o_wren, 0);
        check("rhold_ready_in_reset", bus.s_ready, 0);
        next_cycle();
        reset = 1'b0;
        #1;
        check("rhold_no_write", wr_q.size(), n_before);
        check("rhold_busy", o_busy, 0);
        check("rhold_wrdata", bus.o_wrdata, 0);
        check("rhold_word_cnt", o_word_cnt, 0);

        // ---- throttle delay with data streaming alongside
        thr_pat = '0;
        for (int i = 0; i < 5; i++) begin
            bus.i_alm_full = (i < 3);
            bus.s_valid    = (i < 4);
            bus.s_data     = (i < 4) ? (32'h5A000000 | i) : 32'h0;
            bus.s_last     = (i == 3);
            #1;
            thr_pat[i] = o_throttle;
            if (i == 4) begin
                check("thr_data_wren", bus.o_wren, 1);
                check("thr_data_word", bus.o_wrdata, 128'h5A000003_5A000002_5A000001_5A000000);
            end
            next_cycle();
        end
        idle();
        check("thr_pattern", thr_pat, 5'b01110);
        check("thr_word_cnt", o_word_cnt, 1);
        check("thr_pkt_cnt", o_pkt_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
